// File: rtl/mem_ctrl_v2.sv
// Memory control unit for the Simple CPU v2: registered req/ack handshake toward
// the CPU, synchronous-SRAM strobes toward memory, programmable wait states.
module mem_ctrl_v2 #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_adrs,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_ws_range
    $error("mem_ctrl_v2: WAIT_STATES must be within 0..15");
  end
  if ((DATA_W < 1) || (DATA_W > 32) || (ADDR_W < 1) || (ADDR_W > 32)) begin : g_width_range
    $error("mem_ctrl_v2: DATA_W and ADDR_W must be within 1..32");
  end

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_s;
  logic              rw_r;
  logic              rw_s;
  logic              accept_s;
  logic              capture_s;
  logic              en_s;
  logic              we_s;
  logic              ack_s;
  logic              mem_en_r;
  logic              mem_we_r;
  logic              cpu_ack_r;
  logic              busy_r;
  logic [ADDR_W-1:0] mem_adrs_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] cpu_rdata_r;

  // Next-state, counter and next-output decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cpu_req) begin
          accept_s = 1'b1;
          state_s  = ST_ACCESS;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_s = WS_CNT;
        if (WS_CNT == 4'd0) begin
          state_s   = ST_DONE;
          capture_s = rw_r;
        end else begin
          state_s   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter value 1 marks the last wait cycle; anything lower is treated the same.
        if (cnt_r <= 4'd1) begin
          cnt_s     = 4'd0;
          state_s   = ST_DONE;
          capture_s = rw_r;
        end else begin
          cnt_s     = cnt_r - 4'd1;
          state_s   = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    if (accept_s) begin
      rw_s = cpu_rw;
    end else begin
      rw_s = rw_r;
    end

    en_s  = (state_s == ST_ACCESS) || (state_s == ST_WAIT);
    we_s  = en_s & ~rw_s;
    ack_s = (state_s == ST_DONE);
  end

  // State, counter and registered outputs; outputs are computed from the next state
  // so every strobe toggles exactly on the edge that changes the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      rw_r        <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      cpu_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
      mem_adrs_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      cpu_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rw_r      <= rw_s;
      mem_en_r  <= en_s;
      mem_we_r  <= we_s;
      cpu_ack_r <= ack_s;
      busy_r    <= en_s;
      if (accept_s) begin
        mem_adrs_r  <= cpu_adrs;
        mem_wdata_r <= cpu_wdata;
      end else begin
        mem_adrs_r  <= mem_adrs_r;
        mem_wdata_r <= mem_wdata_r;
      end
      if (capture_s) begin
        cpu_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign cpu_ack   = cpu_ack_r;
  assign busy      = busy_r;
  assign mem_adrs  = mem_adrs_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_rdata = cpu_rdata_r;

endmodule

// File: tb/tb_mem_ctrl_v2.sv
// Bench for mem_ctrl_v2: three instances (0, 1 and 3 wait states) share stimulus and
// are compared every cycle against a timestamp-based transaction model.
module tb_mem_ctrl_v2;

  localparam int WS_TAB [3] = '{0, 1, 3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_rw = 1'b0;
  logic [7:0] cpu_adrs = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic [7:0] mem_rdata = 8'h00;

  logic [2:0] en_v, we_v, ack_v, busy_v;
  logic [7:0] madrs_v [3];
  logic [7:0] mwd_v   [3];
  logic [7:0] crd_v   [3];

  int n_cmp = 0;
  int n_bad = 0;

  // transaction model: acceptance timestamps per instance
  int         t_m;
  int         acc_m  [3];
  bit         act_m  [3];
  bit         rw_m   [3];
  logic [7:0] adrs_m [3];
  logic [7:0] wd_m   [3];
  logic [7:0] rd_m   [3];

  always #5 clk = ~clk;

  mem_ctrl_v2 #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adrs(cpu_adrs),
    .cpu_wdata(cpu_wdata), .cpu_rdata(crd_v[0]), .cpu_ack(ack_v[0]), .busy(busy_v[0]),
    .mem_en(en_v[0]), .mem_we(we_v[0]), .mem_adrs(madrs_v[0]), .mem_wdata(mwd_v[0]),
    .mem_rdata(mem_rdata));

  mem_ctrl_v2 #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adrs(cpu_adrs),
    .cpu_wdata(cpu_wdata), .cpu_rdata(crd_v[1]), .cpu_ack(ack_v[1]), .busy(busy_v[1]),
    .mem_en(en_v[1]), .mem_we(we_v[1]), .mem_adrs(madrs_v[1]), .mem_wdata(mwd_v[1]),
    .mem_rdata(mem_rdata));

  mem_ctrl_v2 #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adrs(cpu_adrs),
    .cpu_wdata(cpu_wdata), .cpu_rdata(crd_v[2]), .cpu_ack(ack_v[2]), .busy(busy_v[2]),
    .mem_en(en_v[2]), .mem_we(we_v[2]), .mem_adrs(madrs_v[2]), .mem_wdata(mwd_v[2]),
    .mem_rdata(mem_rdata));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    t_m = 0;
    for (int k = 0; k < 3; k++) begin
      act_m[k] = 1'b0; acc_m[k] = 0; rw_m[k] = 1'b0;
      adrs_m[k] = 8'h00; wd_m[k] = 8'h00; rd_m[k] = 8'h00;
    end
  endtask

  // A transfer accepted at edge a is enabled after edges a..a+WS, acked after edge
  // a+WS+1 (read data captured there) and the next request can be taken at a+WS+2.
  task automatic model_edge();
    t_m = t_m + 1;
    for (int k = 0; k < 3; k++) begin
      int d;
      d = t_m - acc_m[k];
      if (act_m[k] && (d == WS_TAB[k] + 1) && rw_m[k]) rd_m[k] = mem_rdata;
      if (cpu_req && (!act_m[k] || d >= WS_TAB[k] + 2)) begin
        act_m[k] = 1'b1; acc_m[k] = t_m; rw_m[k] = cpu_rw;
        adrs_m[k] = cpu_adrs; wd_m[k] = cpu_wdata;
      end
    end
  endtask

  task automatic model_compare();
    for (int k = 0; k < 3; k++) begin
      int  d;
      bit  e_en, e_ack;
      d     = t_m - acc_m[k];
      e_en  = act_m[k] && (d <= WS_TAB[k]);
      e_ack = act_m[k] && (d == WS_TAB[k] + 1);
      check($sformatf("model ws%0d mem_en", WS_TAB[k]), en_v[k], e_en);
      check($sformatf("model ws%0d mem_we", WS_TAB[k]), we_v[k], e_en && !rw_m[k]);
      check($sformatf("model ws%0d cpu_ack", WS_TAB[k]), ack_v[k], e_ack);
      check($sformatf("model ws%0d busy", WS_TAB[k]), busy_v[k], e_en);
      check($sformatf("model ws%0d mem_adrs", WS_TAB[k]), madrs_v[k], adrs_m[k]);
      check($sformatf("model ws%0d mem_wdata", WS_TAB[k]), mwd_v[k], wd_m[k]);
      check($sformatf("model ws%0d cpu_rdata", WS_TAB[k]), crd_v[k], rd_m[k]);
    end
  endtask

  // one clock: model follows the edge, outputs are checked on the falling edge
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    model_compare();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic req, input logic rw, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] rd);
    cpu_req = req; cpu_rw = rw; cpu_adrs = a; cpu_wdata = wd; mem_rdata = rd;
  endtask

  typedef struct {
    logic       req, rw;
    logic [7:0] adrs, wd, rd;
    logic       en, we, ack, busy;
    logic [7:0] madrs, mwd, crd;
  } vec_t;

  vec_t tab [8];
  int   acks;

  initial begin
    // zero-wait-state vectors: read 0x3C, write 0x10, then a back-to-back read
    tab[0] = '{1'b1, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h00};
    tab[1] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5};
    tab[2] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5};
    tab[3] = '{1'b1, 1'b0, 8'h10, 8'h5A, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 8'hA5};
    tab[4] = '{1'b1, 1'b1, 8'h20, 8'h77, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h5A, 8'hA5};
    tab[5] = '{1'b1, 1'b1, 8'h20, 8'h77, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h77, 8'hA5};
    tab[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 8'hC3};
    tab[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h77, 8'hC3};

    // reset held for three cycles, then one idle cycle
    do_reset(3);
    step();
    for (int k = 0; k < 3; k++) begin
      check("reset mem_en", en_v[k], 1'b0);
      check("reset cpu_ack", ack_v[k], 1'b0);
      check("reset busy", busy_v[k], 1'b0);
      check("reset mem_adrs", madrs_v[k], 8'h00);
      check("reset cpu_rdata", crd_v[k], 8'h00);
    end

    for (int i = 0; i < 8; i++) begin
      drive(tab[i].req, tab[i].rw, tab[i].adrs, tab[i].wd, tab[i].rd);
      step();
      check($sformatf("vec%0d mem_en", i), en_v[0], tab[i].en);
      check($sformatf("vec%0d mem_we", i), we_v[0], tab[i].we);
      check($sformatf("vec%0d cpu_ack", i), ack_v[0], tab[i].ack);
      check($sformatf("vec%0d busy", i), busy_v[0], tab[i].busy);
      check($sformatf("vec%0d mem_adrs", i), madrs_v[0], tab[i].madrs);
      check($sformatf("vec%0d mem_wdata", i), mwd_v[0], tab[i].mwd);
      check($sformatf("vec%0d cpu_rdata", i), crd_v[0], tab[i].crd);
    end

    // write with three wait states; address/data toggled while busy
    do_reset(2);
    drive(1'b1, 1'b0, 8'h10, 8'h5A, 8'h00);
    step();
    for (int i = 0; i < 4; i++) begin
      check("ws3 write mem_en", en_v[2], 1'b1);
      check("ws3 write mem_we", we_v[2], 1'b1);
      check("ws3 write mem_adrs", madrs_v[2], 8'h10);
      check("ws3 write mem_wdata", mwd_v[2], 8'h5A);
      check("ws3 write no ack", ack_v[2], 1'b0);
      drive(1'b0, $urandom_range(0, 1), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    check("ws3 write ack", ack_v[2], 1'b1);
    check("ws3 write en off", en_v[2], 1'b0);
    check("ws3 write rdata kept", crd_v[2], 8'h00);
    step();
    check("ws3 single ack", ack_v[2], 1'b0);

    // back-to-back write then read with one wait state
    do_reset(2);
    acks = 0;
    drive(1'b1, 1'b0, 8'h41, 8'h99, 8'h00);
    step(); acks += int'(ack_v[1]);
    check("b2b wr en", en_v[1], 1'b1);
    check("b2b wr we", we_v[1], 1'b1);
    drive(1'b1, 1'b1, 8'h42, 8'h00, 8'h6E);
    step(); acks += int'(ack_v[1]);
    check("b2b wr adrs held", madrs_v[1], 8'h41);
    check("b2b wr wdata held", mwd_v[1], 8'h99);
    step(); acks += int'(ack_v[1]);
    check("b2b first ack", ack_v[1], 1'b1);
    check("b2b gap en", en_v[1], 1'b0);
    step(); acks += int'(ack_v[1]);
    check("b2b rd en", en_v[1], 1'b1);
    check("b2b rd we", we_v[1], 1'b0);
    check("b2b rd adrs", madrs_v[1], 8'h42);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h6E);
    step(); acks += int'(ack_v[1]);
    step(); acks += int'(ack_v[1]);
    check("b2b second ack", ack_v[1], 1'b1);
    check("b2b rdata", crd_v[1], 8'h6E);
    step(); acks += int'(ack_v[1]);
    check("b2b ack count", acks, 2);

    // reset pulled during WAIT; nothing is acknowledged, next transfer completes
    do_reset(2);
    drive(1'b1, 1'b1, 8'h55, 8'h00, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h55, 8'h00, 8'h00);
    step();
    check("midrst in wait", en_v[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst async en", en_v[2], 1'b0);
    check("midrst async busy", busy_v[2], 1'b0);
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst no ack", ack_v[2], 1'b0);
    end
    drive(1'b1, 1'b1, 8'h66, 8'h00, 8'hB7);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'hB7);
    for (int i = 0; i < 3; i++) begin
      check("post-rst en", en_v[2], 1'b1);
      step();
    end
    check("post-rst last en", en_v[2], 1'b1);
    step();
    check("post-rst ack", ack_v[2], 1'b1);
    check("post-rst rdata", crd_v[2], 8'hB7);

    // random traffic with occasional resets, checked only by the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), 8'($urandom),
              8'($urandom), 8'($urandom));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
